// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer:
// opcodes, FSM states and ALU control codes.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_RESP = 2'b11
    } state_e;

    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_OR  = 2'b11;

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer around an external combinational ALU.
// Single ops take one ALU cycle; MUL is shift-add over n cycles.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_num,
    output logic         rsp_neg,
    output logic         rsp_cero,
    output logic         rsp_carry,
    output logic         rsp_err,
    output logic [n-1:0] alu_src1,
    output logic [n-1:0] alu_src2,
    output logic [1:0]   alu_control,
    input  logic [n-1:0] alu_num,
    input  logic         alu_neg,
    input  logic         alu_cero,
    input  logic         alu_carry
);

    localparam int CW = $clog2(n) + 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_e        state;
    logic [1:0]    op_q;
    logic [n-1:0]  acc;
    logic [n-1:0]  mcand;
    logic [n-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic [n-1:0]  acc_next;

    // mcand/mplier double as the a/b operands for single ops
    assign cmd_ready = (state == S_IDLE);
    assign acc_next  = mplier[0] ? alu_num : acc;

    // Drive the ALU only while an operation is in flight
    always_comb begin
        alu_src1    = '0;
        alu_src2    = '0;
        alu_control = ALUC_ADD;
        unique case (state)
            S_EXEC: begin
                alu_src1    = mcand;
                alu_src2    = mplier;
                alu_control = op_q;
            end
            S_MUL: begin
                alu_src1    = acc;
                alu_src2    = mcand;
                alu_control = ALUC_ADD;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= ALUC_ADD;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_num   <= '0;
            rsp_neg   <= 1'b0;
            rsp_cero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op[1:0];
                        mcand  <= cmd_a;
                        mplier <= cmd_b;
                        acc    <= '0;
                        cnt    <= '0;
                        if (!cmd_op[2]) begin
                            state <= S_EXEC;
                        end else if (cmd_op == OP_MUL) begin
                            state <= S_MUL;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_num   <= '0;
                            rsp_neg   <= 1'b0;
                            rsp_cero  <= 1'b0;
                            rsp_carry <= 1'b0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_num   <= alu_num;
                    rsp_neg   <= alu_neg;
                    rsp_cero  <= alu_cero;
                    rsp_carry <= alu_carry;
                    rsp_err   <= 1'b0;
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_num   <= acc_next;
                        rsp_neg   <= 1'b0;
                        rsp_cero  <= (acc_next == '0);
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
